waveform_trace_renderer: RTL and testbench
==========================================

# waveform_trace_renderer

Multi-channel oscilloscope trace renderer for the VGA display path. It stores one screen-width of samples per channel in line buffers, maps each sample to a screen row, and draws connected traces: each column spans from the previous column's row to the current one, so steep edges render without gaps. It sits between the sample source (ADC/DSP output) and the pixel colour mux, fed by the VGA timing generator's pixel coordinates. Run and single-shot capture modes are supported.

## Interface
- N_CH, 2: number of channels
- SAMPLE_W, 12: sample width (unsigned)
- PIX_W, 10: pixel coordinate width
- DEPTH, 800: columns stored per channel (= H active)
- V_ACTIVE, 600: visible rows; row mapping clamps to V_ACTIVE-1
- Y_OFFSET, 300: row of sample value 0
- SCALE_SHIFT, 3: sample right-shift before offset
- THICK, 2: trace thickness in rows
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = RUN, 1 = SINGLE
- arm  in  1  one-cycle pulse, starts a SINGLE capture
- wr_valid  in  1  sample write request
- wr_ch  in  clog2(N_CH)  target channel
- wr_data  in  SAMPLE_W  sample value
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- done  out  1  SINGLE capture complete (FROZEN)
- pix_valid  in  1  pixel_x/pixel_y in active area
- pixel_x  in  PIX_W  current column
- pixel_y  in  PIX_W  current row
- pixel_on  out  N_CH  per-channel trace hit, registered

## Operation
- Per channel: DEPTH-entry buffer, write pointer wr_ptr[ch]; each accepted write stores at wr_ptr[wr_ch] and increments it. At most one write per cycle.
- Row map: row = Y_OFFSET + (value >> SCALE_SHIFT), computed at full width, clamped to V_ACTIVE-1.
- States: RUN, IDLE, FILLING, FROZEN.
- RUN: wr_ready=1; wr_ptr wraps DEPTH-1 -> 0 (overwrite, tearing allowed).
- IDLE: wr_ready=0. arm -> FILLING, all wr_ptr cleared to 0.
- FILLING: wr_ready = !full[wr_ch]; full[ch] sets when wr_ptr[ch] reaches DEPTH (no wrap). All channels full -> FROZEN.
- FROZEN: wr_ready=0, done=1, buffers held; arm -> FILLING (pointers cleared, done=0).
- Mode: mode=0 forces RUN next cycle from any state; mode=1 while in RUN -> IDLE. arm is ignored in RUN.
- Concurrent write and final-fill: the write completing the last channel is stored; FROZEN is entered the next cycle.
- Display: for column x, cur = row(buf[x]), prev = row(buf[x-1]); at x=0, prev = cur. lo = min(prev,cur), hi = max(prev,cur). pixel_on[ch] = pix_valid && x < DEPTH && lo <= y <= hi+THICK-1.
- The buffer read port is independent of writes; a same-address write and read return old data.

## Timing
- Reset: state = IDLE if mode=1, else RUN; wr_ptr=0, full=0, done=0, pixel_on=0, pipeline valids=0. Buffer contents are not reset.
- Display latency: 2 clocks from pixel_x/pixel_y/pix_valid to pixel_on (stage 1 sync RAM read plus coordinate delay; stage 2 map/compare register). prev is taken from the stage-1 read of the previous column, held as x advances, and re-seeded at x=0.
- wr_ready is combinational from state, full and wr_ch; the write occurs on the accepting clock edge.
- rst_n assertion mid-capture clears state, pointers and pixel_on immediately (asynchronous).

## Structure
- Package waveform_pkg: state enum, mode encoding, row-map function (shift, offset, clamp).
- Sub-module trace_sample_ram: simple dual-port RAM, 1 write and 1 sync read, DEPTH x SAMPLE_W, instantiated N_CH times.
- Top level: capture FSM, pointers, 2-stage display pipeline.

## Test plan
- Reset with mode=1 -> wr_ready=0, done=0, pixel_on=0; after arm, wr_ready=1.
- RUN: ch0 col0=0 (row 300), col1=80 (row 310); scan x=1 -> pixel_on[0]=1 for y=300..311, 0 at y=299 and 312, 2 clocks after the inputs.
- Clamp: col5=4095 -> 511+300=811 clamps to 599; x=5 with col4=4095 -> on at y=599 only within the visible area.
- x=0 with col0=160 (row 320) -> on at y=320..321 only, no link to col DEPTH-1. Also x=DEPTH -> off.
- SINGLE: arm, write 800 samples to ch0 -> full[0]=1, wr_ready=0 for ch0 and 1 for ch1; after 800 ch1 writes -> done=1 next cycle. In RUN, write 801 samples -> col0 holds the 801st.
- Pull rst_n low after 400 FILLING writes -> state IDLE, wr_ptr=0, done=0, pixel_on=0 with no clock edge required.

Source files
------------

// File: rtl/waveform_pkg.sv
// Shared types and the sample-to-row mapping for the waveform trace renderer.
package waveform_pkg;

  typedef enum logic [1:0] {
    S_RUN,
    S_IDLE,
    S_FILL,
    S_FROZEN
  } state_t;

  localparam logic MODE_RUN    = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

  function automatic logic [31:0] row_map(
    input logic [31:0] v,
    input int unsigned sh,
    input int unsigned off,
    input int unsigned vmax
  );
    logic [31:0] r;
    r = off + (v >> sh);
    return (r > vmax - 1) ? vmax - 1 : r;
  endfunction

endpackage

// File: rtl/trace_sample_ram.sv
// Simple dual-port sample buffer: one write port, one synchronous read port.
module trace_sample_ram #(
  parameter int DEPTH = 800,
  parameter int W     = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/waveform_trace_renderer.sv
// Multi-channel scope trace renderer: capture FSM, line buffers and a
// two-stage display pipeline producing per-channel pixel hits.
module waveform_trace_renderer
  import waveform_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int SAMPLE_W    = 12,
  parameter int PIX_W       = 10,
  parameter int DEPTH       = 800,
  parameter int V_ACTIVE    = 600,
  parameter int Y_OFFSET    = 300,
  parameter int SCALE_SHIFT = 3,
  parameter int THICK       = 2,
  parameter int CW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic                arm,
  input  logic                wr_valid,
  input  logic [CW-1:0]       wr_ch,
  input  logic [SAMPLE_W-1:0] wr_data,
  output logic                wr_ready,
  output logic                done,
  input  logic                pix_valid,
  input  logic [PIX_W-1:0]    pixel_x,
  input  logic [PIX_W-1:0]    pixel_y,
  output logic [N_CH-1:0]     pixel_on
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);

  state_t              r_state, w_next;
  logic [PW-1:0]       r_ptr [N_CH];
  logic [N_CH-1:0]     r_full, w_full_nxt;
  logic                w_accept, w_arm_fill, w_last_wr, w_wrap;
  logic [SAMPLE_W-1:0] w_rd [N_CH];

  assign w_accept   = wr_valid && wr_ready;
  assign w_arm_fill = (mode == MODE_SINGLE) && arm &&
                      (r_state == S_IDLE || r_state == S_FROZEN);
  assign w_last_wr  = r_ptr[wr_ch] == PW'(DEPTH - 1);
  assign w_wrap     = r_ptr[wr_ch] >= PW'(DEPTH - 1);

  // Include the in-flight write so the final fill freezes on the same edge.
  always_comb begin
    w_full_nxt = r_full;
    if (w_accept && r_state == S_FILL && w_last_wr)
      w_full_nxt[wr_ch] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= (mode == MODE_SINGLE) ? S_IDLE : S_RUN;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (mode == MODE_RUN) begin
      w_next = S_RUN;
    end else begin
      unique case (r_state)
        S_RUN:           w_next = S_IDLE;
        S_IDLE,
        S_FROZEN:        if (arm) w_next = S_FILL;
        S_FILL:          if (&w_full_nxt) w_next = S_FROZEN;
        default:         w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ready = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      S_RUN:    wr_ready = 1'b1;
      S_FILL:   wr_ready = !r_full[wr_ch];
      S_FROZEN: done     = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) r_ptr[c] <= '0;
      r_full <= '0;
    end else if (w_arm_fill) begin
      for (int c = 0; c < N_CH; c++) r_ptr[c] <= '0;
      r_full <= '0;
    end else if (w_accept) begin
      r_ptr[wr_ch] <= (r_state == S_RUN && w_wrap) ?
                      '0 : r_ptr[wr_ch] + PW'(1);
      r_full       <= w_full_nxt;
    end
  end

  logic          w_xin;
  logic [AW-1:0] w_raddr;

  assign w_xin   = pix_valid && (32'(pixel_x) < DEPTH);
  assign w_raddr = w_xin ? AW'(pixel_x) : '0;

  for (genvar g = 0; g < N_CH; g++) begin : g_ram
    trace_sample_ram #(
      .DEPTH (DEPTH),
      .W     (SAMPLE_W),
      .AW    (AW)
    ) u_ram (
      .clk     (clk),
      .i_we    (w_accept && wr_ch == CW'(g)),
      .i_waddr (AW'(r_ptr[g])),
      .i_wdata (wr_data),
      .i_raddr (w_raddr),
      .o_rdata (w_rd[g])
    );
  end

  logic             r_s1_vld;
  logic [PIX_W-1:0] r_s1_x, r_s1_y, r_last_x;
  logic [31:0]      r_last_row [N_CH];
  logic [31:0]      r_prev_row [N_CH];
  logic [31:0]      w_cur [N_CH];
  logic [31:0]      w_prev [N_CH];
  logic [N_CH-1:0]  w_on;

  // prev tracks the row of the column before the one currently held.
  always_comb begin
    logic [31:0] lo, hi, yy;
    w_on = '0;
    yy   = 32'(r_s1_y);
    for (int c = 0; c < N_CH; c++) begin
      w_cur[c] = row_map(32'(w_rd[c]), SCALE_SHIFT, Y_OFFSET, V_ACTIVE);
      if (r_s1_x == '0)            w_prev[c] = w_cur[c];
      else if (r_s1_x == r_last_x) w_prev[c] = r_prev_row[c];
      else                         w_prev[c] = r_last_row[c];
      lo = (w_prev[c] < w_cur[c]) ? w_prev[c] : w_cur[c];
      hi = (w_prev[c] < w_cur[c]) ? w_cur[c] : w_prev[c];
      w_on[c] = r_s1_vld && (yy >= lo) && (yy <= hi + 32'(THICK) - 32'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_x   <= '0;
      r_s1_y   <= '0;
      r_last_x <= '1;
      pixel_on <= '0;
      for (int c = 0; c < N_CH; c++) begin
        r_last_row[c] <= '0;
        r_prev_row[c] <= '0;
      end
    end else begin
      r_s1_vld <= w_xin;
      r_s1_x   <= pixel_x;
      r_s1_y   <= pixel_y;
      pixel_on <= w_on;
      if (r_s1_vld && r_s1_x != r_last_x) begin
        r_last_x <= r_s1_x;
        for (int c = 0; c < N_CH; c++) begin
          r_prev_row[c] <= r_last_row[c];
          r_last_row[c] <= w_cur[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_waveform_trace_renderer.sv
// Directed bench for waveform_trace_renderer: capture modes, row mapping,
// trace linking, clamping and asynchronous reset.
module tb_waveform_trace_renderer;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        arm;
  logic        wr_valid;
  logic [0:0]  wr_ch;
  logic [11:0] wr_data;
  logic        wr_ready;
  logic        done;
  logic        pix_valid;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [1:0]  pixel_on;

  int n_tot = 0;
  int n_bad = 0;

  waveform_trace_renderer u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .arm       (arm),
    .wr_valid  (wr_valid),
    .wr_ch     (wr_ch),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .done      (done),
    .pix_valid (pix_valid),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .pixel_on  (pixel_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wr(input int ch, input int d);
    wr_valid = 1'b1;
    wr_ch    = 1'(ch);
    wr_data  = 12'(d);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic probe(input string tag, input int x, input int y,
                       input logic exp);
    pix_valid = 1'b1;
    pixel_x   = 10'(x);
    pixel_y   = 10'(y);
    repeat (2) @(posedge clk);
    #1;
    chk(tag, 32'(pixel_on[0]), 32'(exp));
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; mode = 1'b1; arm = 1'b0;
    wr_valid = 1'b0; wr_ch = '0; wr_data = '0;
    pix_valid = 1'b0; pixel_x = '0; pixel_y = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(wr_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pix", 32'(pixel_on), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready", 32'(wr_ready), 0);

    pulse_arm();
    chk("arm_ready", 32'(wr_ready), 1);

    for (int i = 0; i < 800; i++)
      wr(0, (i == 1) ? 80 : (i == 4 || i == 5) ? 4095 : 0);
    wr_ch = 1'b0;
    #1 chk("full0_rdy0", 32'(wr_ready), 0);
    wr_ch = 1'b1;
    #1 chk("full0_rdy1", 32'(wr_ready), 1);
    for (int i = 0; i < 799; i++) wr(1, 0);
    chk("pre_done", 32'(done), 0);
    wr(1, 0);
    chk("done", 32'(done), 1);
    wr_ch = 1'b1;
    #1 chk("frozen_rdy", 32'(wr_ready), 0);

    probe("x0_y300", 0, 300, 1'b1);
    probe("x1_y299", 1, 299, 1'b0);
    probe("x1_y300", 1, 300, 1'b1);
    probe("x1_y305", 1, 305, 1'b1);
    probe("x1_y311", 1, 311, 1'b1);
    probe("x1_y312", 1, 312, 1'b0);
    probe("x4_y599", 4, 599, 1'b1);
    probe("x5_y599", 5, 599, 1'b1);
    probe("x5_y598", 5, 598, 1'b0);
    probe("x800", 800, 300, 1'b0);
    pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("pixinv", 32'(pixel_on), 0);

    pulse_arm();
    chk("rearm_done", 32'(done), 0);
    pix_valid = 1'b1; pixel_x = 10'd0; pixel_y = 10'd300;
    for (int i = 0; i < 400; i++) wr(0, 0);
    chk("fill_pix", 32'(pixel_on[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    wr_ch = 1'b0;
    #1;
    chk("arst_ready", 32'(wr_ready), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_pix", 32'(pixel_on), 0);
    pix_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mode = 1'b0;
    @(posedge clk);
    #1 chk("run_ready", 32'(wr_ready), 1);

    for (int i = 0; i < 801; i++)
      wr(0, (i == 799) ? 4095 : (i == 800) ? 160 : 0);
    probe("w_x0_y319", 0, 319, 1'b0);
    probe("w_x0_y320", 0, 320, 1'b1);
    probe("w_x0_y321", 0, 321, 1'b1);
    probe("w_x0_y322", 0, 322, 1'b0);
    probe("w_x0_y599", 0, 599, 1'b0);
    probe("w_x799", 799, 599, 1'b1);
    pix_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
